// File: rtl/imm_seq_ctrl.sv
// Immediate-operand sequencer: builds 16-bit immediates from 8-bit decode beats
// (zero/sign-extend, high-byte placement, or two-beat concatenation) behind valid/ready.
module imm_seq_ctrl #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [7:0]       req_imm,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_data,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StWaitLo, StResp} state_e;

  state_e           state_q, state_d;
  logic [7:0]       hi_q, hi_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [15:0]      data_q, data_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] done_q, done_d;
  logic             req_fire, rsp_fire;

  assign req_fire = req_valid & req_ready;
  assign rsp_fire = rsp_valid & rsp_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      hi_q    <= 8'h00;
      tmo_q   <= '0;
      data_q  <= 16'h0000;
      err_q   <= 1'b0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    err_d   = 1'b0;
    done_d  = done_q;
    unique case (state_q)
      StIdle: begin
        if (req_fire) begin
          state_d = StResp;
          unique case (req_op)
            2'b00: data_d = {8'h00, req_imm};
            2'b01: data_d = {{8{req_imm[7]}}, req_imm};
            2'b10: data_d = {req_imm, 8'h00};
            2'b11: begin
              hi_d    = req_imm;
              tmo_d   = '0;
              state_d = StWaitLo;
            end
          endcase
        end
      end
      StWaitLo: begin
        // A low beat on the final waiting cycle takes priority over the abort.
        if (req_fire) begin
          data_d  = {hi_q, req_imm};
          state_d = StResp;
        end else if (tmo_q == TmoLast) begin
          tmo_d   = '0;
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      StResp: begin
        if (rsp_fire) begin
          done_d  = done_q + CNT_W'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready = (state_q != StResp);
    rsp_valid = (state_q == StResp);
    busy      = (state_q != StIdle);
    rsp_data  = data_q;
    err       = err_q;
    done_cnt  = done_q;
  end

endmodule
